// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the round-iterative AES-128 decryptor.
// The S-boxes are computed as inverse-plus-affine transforms rather than stored as tables.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        LAST  = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_ARK   = 2'd0,
        SEL_ROUND = 2'd1,
        SEL_LAST  = 2'd2
    } rsel_e;

    localparam int ROUND_W = 4;
    typedef logic [ROUND_W-1:0] rnd_t;
    typedef logic [127:0]       blk_t;

    localparam rnd_t NUM_ROUNDS      = 4'd10;
    localparam rnd_t FIRST_INV_ROUND = 4'd9;
    localparam rnd_t LAST_ROUND      = 4'd0;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // Forward key schedule from the cipher key, returning the key for round rnd.
    function automatic blk_t round_key(input blk_t key, input rnd_t rnd);
        blk_t        k;
        blk_t        rk;
        logic [31:0] t;
        logic [7:0]  rcon;
        k    = key;
        rk   = key;
        rcon = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon, 24'h0};
            k[127:96] = k[127:96] ^ t;
            k[95:64]  = k[95:64]  ^ k[127:96];
            k[63:32]  = k[63:32]  ^ k[95:64];
            k[31:0]   = k[31:0]   ^ k[63:32];
            if (rnd == rnd_t'(i)) rk = k;
            rcon = xtime(rcon);
        end
        return rk;
    endfunction

    function automatic blk_t inv_mix_columns(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_ctrl_if.sv
// Ciphertext/key input and plaintext output handshakes of the iterative AES decryptor.
interface aes_decrypt_iter_ctrl_if #(
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] cipher_in;
    logic [DATA_W-1:0] key_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] plain_out;

    modport master (
        output in_valid, cipher_in, key_in, out_ready,
        input  in_ready, out_valid, plain_out
    );

    modport slave (
        input  in_valid, cipher_in, key_in, out_ready,
        output in_ready, out_valid, plain_out
    );
endinterface

// File: rtl/aes_dec_round_sel.sv
// Single shared inverse-round datapath: AddRoundKey, full inverse round and final round,
// selected by round type. The round counter doubles as the round-key index in every state.
module aes_dec_round_sel
    import aes_dec_pkg::*;
(
    input  blk_t  i_state,
    input  blk_t  i_key,
    input  rnd_t  i_round,
    input  rsel_e i_sel,
    output blk_t  o_state
);
    blk_t w_rk;
    blk_t w_isb;
    blk_t w_add_round_key;
    blk_t w_inverse_round;
    blk_t w_inverse_last_round;

    assign w_rk = round_key(i_key, i_round);

    // InvShiftRows folded into the byte routing of each InvSubBytes lane.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane
        localparam int COL = gi / 4;
        localparam int ROW = gi % 4;
        localparam int SRC = (((COL - ROW + 4) % 4) * 4) + ROW;
        assign w_isb[127-8*gi -: 8] = inv_sbox(i_state[127-8*SRC -: 8]);
    end

    // Inner and final rounds share the same front end; only InvMixColumns differs.
    assign w_add_round_key      = i_state ^ w_rk;
    assign w_inverse_last_round = w_isb ^ w_rk;
    assign w_inverse_round      = inv_mix_columns(w_inverse_last_round);

    always_comb begin
        o_state = w_inverse_round;
        case (i_sel)
            SEL_ARK:   o_state = w_add_round_key;
            SEL_ROUND: o_state = w_inverse_round;
            SEL_LAST:  o_state = w_inverse_last_round;
            default:   o_state = w_inverse_round;
        endcase
    end
endmodule

// File: rtl/aes_decrypt_iter_ctrl.sv
// Round-iterative AES-128 decryption controller: one block per 11 datapath cycles.
// Define AES_DEC_BLK_CNT_EN to enable the completed-block counter on blocks_done.
module aes_decrypt_iter_ctrl
    import aes_dec_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_decrypt_iter_ctrl_if.slave bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       blocks_done
);
    state_e            r_fsm;
    state_e            w_fsm_next;
    rnd_t              r_round;
    rnd_t              w_round_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_next;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] w_key_next;
    logic [DATA_W-1:0] r_plain;
    logic [DATA_W-1:0] w_plain_next;
    logic              r_out_valid;
    logic              w_out_valid_next;
    rsel_e             w_sel;
    blk_t              w_dp;

    assign w_sel = (r_fsm == INIT) ? SEL_ARK : ((r_fsm == LAST) ? SEL_LAST : SEL_ROUND);

    aes_dec_round_sel u_round_sel (
        .i_state (r_data),
        .i_key   (r_key),
        .i_round (r_round),
        .i_sel   (w_sel),
        .o_state (w_dp)
    );

    always_comb begin
        w_fsm_next       = r_fsm;
        w_round_next     = r_round;
        w_data_next      = r_data;
        w_key_next       = r_key;
        w_plain_next     = r_plain;
        w_out_valid_next = r_out_valid;
        case (r_fsm)
            IDLE: begin
                if (bus.in_valid) begin
                    w_data_next  = bus.cipher_in;
                    w_key_next   = bus.key_in;
                    w_round_next = rnd_t'(NUM_ROUNDS);
                    w_fsm_next   = INIT;
                end
            end
            INIT: begin
                w_data_next  = w_dp;
                w_round_next = FIRST_INV_ROUND;
                w_fsm_next   = ROUND;
            end
            ROUND: begin
                w_data_next = w_dp;
                if (r_round == rnd_t'(1)) begin
                    w_round_next = LAST_ROUND;
                    w_fsm_next   = LAST;
                end else begin
                    w_round_next = r_round - rnd_t'(1);
                end
            end
            LAST: begin
                w_plain_next     = w_dp;
                w_out_valid_next = 1'b1;
                w_fsm_next       = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_next = 1'b0;
                    w_fsm_next       = IDLE;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
        // A counter above the round count can only come from an upset; recover to IDLE.
        if (r_round > aes_dec_pkg::NUM_ROUNDS) begin
            w_fsm_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_round     <= '0;
            r_data      <= '0;
            r_key       <= '0;
            r_plain     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_round     <= w_round_next;
            r_data      <= w_data_next;
            r_key       <= w_key_next;
            r_plain     <= w_plain_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign bus.in_ready  = (r_fsm == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.plain_out = r_plain;
    assign busy          = (r_fsm != IDLE);

`ifdef AES_DEC_BLK_CNT_EN
    logic [CNT_W-1:0] r_blocks;
    logic             w_done_pulse;

    assign w_done_pulse = (r_fsm == DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blocks <= '0;
        end else if (w_done_pulse) begin
            r_blocks <= r_blocks + CNT_W'(1);
        end
    end

    assign blocks_done = r_blocks;
`else
    assign blocks_done = '0;
`endif
endmodule

// File: tb/tb_aes_decrypt_iter_ctrl.sv
// Bench for aes_decrypt_iter_ctrl: FIPS-197 vectors plus random blocks whose ciphertext
// comes from a forward AES-128 encryption model; the decryptor must return the plaintext.
module tb_aes_decrypt_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] blocks_done;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_blocks = '0;
    logic [7:0]  tb_sbox [256];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decrypt_iter_ctrl_if #(.DATA_W(128)) bus ();

    aes_decrypt_iter_ctrl #(
        .DATA_W     (128),
        .NUM_ROUNDS (10),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mx2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Generator walk over GF(2^8): p steps by 3, q by 1/3, so q is always p's inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            tb_sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        tb_sbox[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   rk [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rcon, a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) rk[i] = key[127-8*i -: 8];
        rcon = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                a0     = tmp[0];
                tmp[0] = tb_sbox[tmp[1]] ^ rcon;
                tmp[1] = tb_sbox[tmp[2]];
                tmp[2] = tb_sbox[tmp[3]];
                tmp[3] = tb_sbox[a0];
                rcon   = mx2(rcon);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[c*4+w] = tb_sbox[s[((c+w)%4)*4+w]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[c*4]; a1 = t[c*4+1]; a2 = t[c*4+2]; a3 = t[c*4+3];
                    s[c*4]   = mx2(a0) ^ mx2(a1) ^ a1 ^ a2 ^ a3;
                    s[c*4+1] = a0 ^ mx2(a1) ^ mx2(a2) ^ a2 ^ a3;
                    s[c*4+2] = a0 ^ a1 ^ mx2(a2) ^ mx2(a3) ^ a3;
                    s[c*4+3] = mx2(a0) ^ a0 ^ a1 ^ a2 ^ mx2(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r*16+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [15:0] exp_cnt();
`ifdef AES_DEC_BLK_CNT_EN
        return exp_blocks;
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic accept(input logic [127:0] ct, input logic [127:0] key, input string name);
        bus.cipher_in = ct;
        bus.key_in    = key;
        bus.in_valid  = 1'b1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            lat++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_result(input int lat, input bit seen, input logic [127:0] pt, input string name);
        n_checks++;
        if (!seen || lat != 11) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want 11", name, lat, seen);
        end
        n_checks++;
        if (bus.plain_out !== pt) begin
            n_fail++;
            $display("FAIL %s plain_out: got %h want %h", name, bus.plain_out, pt);
        end
    endtask

    task automatic release_out(input string name);
        bus.out_ready = 1'b1;
        tick();
        exp_blocks++;
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s release: got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                     name, bus.out_valid, bus.in_ready, busy);
        end
        n_checks++;
        if (blocks_done !== exp_cnt()) begin
            n_fail++;
            $display("FAIL %s blocks_done: got %0d want %0d", name, blocks_done, exp_cnt());
        end
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] pt,
                             input int stall, input string name);
        int lat;
        bit seen;
        accept(ct, key, name);
        wait_out(lat, seen);
        check_result(lat, seen, pt, name);
        repeat (stall) tick();
        release_out(name);
        $display("block %s: ct=%h key=%h plain=%h latency=%0d", name, ct, key, bus.plain_out, lat);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_blocks = '0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.cipher_in = rand128();
        bus.key_in    = rand128();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.out_valid, busy, bus.plain_out, blocks_done} !== {1'b0, 1'b0, 128'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset outputs: got out_valid=%b busy=%b plain=%h blocks=%0d want 0 0 0 0",
                     bus.out_valid, busy, bus.plain_out, blocks_done);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_blocks    = '0;
        tick();
        n_checks++;
        if ({bus.in_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset idle: got in_ready=%b busy=%b want 1 0", bus.in_ready, busy);
        end
        $display("reset: in_ready=%b busy=%b", bus.in_ready, busy);
    endtask

    task automatic test_backpressure();
        int lat;
        bit seen;
        int bad;
        accept(C1_CT, C1_KEY, "backpressure");
        wait_out(lat, seen);
        check_result(lat, seen, C1_PT, "backpressure");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.plain_out} !== {1'b1, 1'b0, C1_PT}) begin
                n_fail++;
                bad++;
                $display("FAIL backpressure hold cycle %0d: got out_valid=%b in_ready=%b plain=%h want 1 0 %h",
                         i, bus.out_valid, bus.in_ready, bus.plain_out, C1_PT);
            end
        end
        release_out("backpressure");
        $display("backpressure: 20 stalled cycles, %0d deviations", bad);
    endtask

    task automatic test_input_change();
        int lat;
        bit seen;
        accept(C1_CT, C1_KEY, "input_change");
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.cipher_in = rand128();
            bus.key_in    = rand128();
            bus.in_valid  = 1'($urandom_range(0, 1));
            tick();
            lat++;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        bus.in_valid = 1'b0;
        check_result(lat, seen, C1_PT, "input_change");
        release_out("input_change");
        $display("input_change: plain=%h latency=%0d", bus.plain_out, lat);
    endtask

    task automatic test_reset_mid();
        int pulses;
        accept(C1_CT, C1_KEY, "reset_mid");
        repeat (5) tick();
        pulse_reset();
        n_checks++;
        if ({bus.out_valid, busy, bus.in_ready, bus.plain_out, blocks_done} !==
            {1'b0, 1'b0, 1'b1, 128'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got out_valid=%b busy=%b in_ready=%b plain=%h blocks=%0d want 0 0 1 0 0",
                     bus.out_valid, busy, bus.in_ready, bus.plain_out, blocks_done);
        end
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid aborted block: got %0d active cycles want 0", pulses);
        end
        $display("reset_mid: aborted at round 5, idle cycles checked");
        run_block(C1_CT, C1_KEY, C1_PT, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [127:0] pt, key;
        for (int i = 0; i < 5; i++) begin
            pt  = rand128();
            key = rand128();
            run_block(model_encrypt(pt, key), key, pt, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt, key;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            pt  = rand128();
            key = rand128();
            run_block(model_encrypt(pt, key), key, pt, 0, "back_to_back");
        end
        n_checks++;
        if (blocks_done !== exp_cnt()) begin
            n_fail++;
            $display("FAIL back_to_back count: got %0d want %0d", blocks_done, exp_cnt());
        end
        $display("back_to_back: blocks_done=%0d", blocks_done);
    endtask

    initial begin
        build_sbox();
        test_reset();
        run_block(C1_CT, C1_KEY, C1_PT, 0, "fips_c1");
        run_block(B_CT, B_KEY, B_PT, 2, "fips_b");
        test_backpressure();
        test_input_change();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
